// File: rtl/adder_arbiter_pkg.sv
// adder_arbiter_pkg: shared types and helpers for the shared-adder arbiter.
//   state_e : FSM states of the shared datapath (idle, calculate, respond)
//   idw()   : requester-index width, at least one bit
package adder_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Index width for n requesters; a single requester still needs one bit.
  function automatic int unsigned idw(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adder_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker.
//   req    in  [NREQ]  request vector
//   ptr    in  [IDW]   highest-priority lane this cycle
//   gnt    out [NREQ]  one-hot grant (zero when no request)
//   gnt_id out [IDW]   index of the granted lane
//   any    out         at least one request present
module rr_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  localparam int unsigned IDW = idw(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id,
  output logic            any
);

  logic [IDW:0]   scan;
  logic [IDW-1:0] idx;

  // Walk lanes ptr, ptr+1, ... wrapping mod NREQ; first hit wins.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    any    = 1'b0;
    scan   = '0;
    idx    = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      scan = {1'b0, ptr} + (IDW+1)'(k);
      if (scan >= (IDW+1)'(NREQ)) scan = scan - (IDW+1)'(NREQ);
      idx = IDW'(scan);
      if (!any && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_id   = idx;
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// adder_arbiter: one registered adder (x + y + cin, W+1 bits) shared by NREQ
// requesters through a round-robin arbiter; results leave on one response channel.
//   clk, rst            clock, synchronous active-high reset
//   req_valid/req_ready per-lane operand handshake (ready is one-hot or zero)
//   req_x/req_y/req_cin lane operands, lane i at [i*W +: W] / bit i
//   rsp_valid/rsp_ready result handshake
//   rsp_id/rsp_sum/rsp_zero  granted lane, zero-extended sum, sum==0 flag
//   op_cnt              saturating response-handshake count, only when
//                       ADDER_ARBITER_STATS_EN is defined
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 8,
  localparam int unsigned IDW = idw(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_valid,
  output logic [NREQ-1:0] req_ready,
  input  logic [NREQ*W-1:0] req_x,
  input  logic [NREQ*W-1:0] req_y,
  input  logic [NREQ-1:0] req_cin,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [IDW-1:0]  rsp_id,
  output logic [W:0]      rsp_sum,
  output logic            rsp_zero
`ifdef ADDER_ARBITER_STATS_EN
  ,
  output logic [15:0]     op_cnt
`endif
);

  state_e         state, next_state;
  logic [IDW-1:0] rr_ptr;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0] gnt_id;
  logic           any;
  logic [W-1:0]   op_x, op_y, sel_x, sel_y;
  logic           op_cin, sel_cin;
  logic [IDW-1:0] op_id;
  logic [W:0]     sum_c;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .any    (any)
  );

  // Grant is only offered while idle and out of reset.
  assign req_ready = gnt & {NREQ{(state == ST_IDLE) && !rst}};

  // Operand mux driven by the one-hot grant.
  always_comb begin
    sel_x   = '0;
    sel_y   = '0;
    sel_cin = 1'b0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (gnt[i]) begin
        sel_x   = req_x[i*W +: W];
        sel_y   = req_y[i*W +: W];
        sel_cin = req_cin[i];
      end
    end
  end

  assign sum_c = {1'b0, op_x} + {1'b0, op_y} + (W+1)'(op_cin);

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (any) next_state = ST_CALC;
      ST_CALC: next_state = ST_RESP;
      ST_RESP: if (rsp_ready) next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Operand capture and round-robin pointer update on grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
      op_x   <= '0;
      op_y   <= '0;
      op_cin <= 1'b0;
      op_id  <= '0;
    end else if (state == ST_IDLE && any) begin
      op_x   <= sel_x;
      op_y   <= sel_y;
      op_cin <= sel_cin;
      op_id  <= gnt_id;
      rr_ptr <= (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + IDW'(1);
    end
  end

  // Result registers; payload holds its last value after the handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      rsp_zero  <= 1'b0;
    end else if (state == ST_CALC) begin
      rsp_valid <= 1'b1;
      rsp_id    <= op_id;
      rsp_sum   <= sum_c;
      rsp_zero  <= (sum_c == '0);
    end else if (state == ST_RESP && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

`ifdef ADDER_ARBITER_STATS_EN
  // Saturating count of response handshakes.
  always_ff @(posedge clk) begin
    if (rst) op_cnt <= '0;
    else if (rsp_valid && rsp_ready && op_cnt != 16'hFFFF) op_cnt <= op_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: directed self-checking bench for adder_arbiter (NREQ=4, W=8).
// Inputs change 1 time unit after the rising edge; outputs are checked after a
// further settle delay, well away from the next edge.
module tb_adder_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned W    = 8;
  localparam int unsigned IDW  = 2;

  logic            clk;
  logic            rst;
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  logic [NREQ*W-1:0] req_x;
  logic [NREQ*W-1:0] req_y;
  logic [NREQ-1:0] req_cin;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [IDW-1:0]  rsp_id;
  logic [W:0]      rsp_sum;
  logic            rsp_zero;
`ifdef ADDER_ARBITER_STATS_EN
  logic [15:0]     op_cnt;
`endif

  int checks = 0;
  int errors = 0;

  adder_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_cin   (req_cin),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_zero  (rsp_zero)
`ifdef ADDER_ARBITER_STATS_EN
    ,
    .op_cnt    (op_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int lane, input logic [7:0] x, input logic [7:0] y, input logic cin);
    req_x[lane*W +: W] = x;
    req_y[lane*W +: W] = y;
    req_cin[lane]      = cin;
  endtask

  // One full operation with rsp_ready=1: grant, calc, response, back to idle.
  task automatic run_op(input string tag, input int lane, input logic [8:0] exp_sum);
    #1;
    check({tag, "_ready"}, 32'(req_ready), 32'(4'b0001 << lane));
    tick();
    check({tag, "_calc_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_calc_valid"}, 32'(rsp_valid), 32'd0);
    tick();
    check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "_id"},    32'(rsp_id),    32'(lane));
    check({tag, "_sum"},   32'(rsp_sum),   32'(exp_sum));
    check({tag, "_zero"},  32'(rsp_zero),  32'(exp_sum == 9'd0));
    tick();
    check({tag, "_done"},  32'(rsp_valid), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '1;
    req_x     = '0;
    req_y     = '0;
    req_cin   = '0;
    rsp_ready = 1'b1;

    // 1. Reset with all lanes valid.
    for (int c = 0; c < 2; c++) begin
      tick();
      check("rst_ready", 32'(req_ready), 32'd0);
      check("rst_valid", 32'(rsp_valid), 32'd0);
      check("rst_sum",   32'(rsp_sum),   32'd0);
    end
    rst = 1'b0;
    #1;
    check("rst_first_gnt", 32'(req_ready), 32'h1);
    req_valid = '0;

    // 2. Single op on lane 2: 0x0F + 0x01 + 1 = 0x011.
    tick();
    set_lane(2, 8'h0F, 8'h01, 1'b1);
    req_valid = 4'b0100;
    #1;
    check("single_ready", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    check("single_calc_ready", 32'(req_ready), 32'd0);
    check("single_calc_valid", 32'(rsp_valid), 32'd0);
    tick();
    check("single_valid", 32'(rsp_valid), 32'd1);
    check("single_id",    32'(rsp_id),    32'd2);
    check("single_sum",   32'(rsp_sum),   32'h011);
    check("single_zero",  32'(rsp_zero),  32'd0);
    tick();
    check("single_done",  32'(rsp_valid), 32'd0);
    check("single_hold_sum", 32'(rsp_sum), 32'h011);

    // 3. Fairness from a fresh pointer: order 0,1,2,3,0,1.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_lane(0, 8'h00, 8'h03, 1'b0);   // 0x003
    set_lane(1, 8'h10, 8'h03, 1'b1);   // 0x014
    set_lane(2, 8'h20, 8'h03, 1'b0);   // 0x023
    set_lane(3, 8'hF0, 8'h20, 1'b1);   // 0x111
    req_valid = 4'b1111;
    run_op("fair0", 0, 9'h003);
    run_op("fair1", 1, 9'h014);
    run_op("fair2", 2, 9'h023);
    run_op("fair3", 3, 9'h111);
    run_op("fair4", 0, 9'h003);
    run_op("fair5", 1, 9'h014);
    req_valid = '0;

    // 4. Width limits, lane 1 alone and served back to back (pointer now 2).
    set_lane(1, 8'hFF, 8'hFF, 1'b1);
    req_valid = 4'b0010;
    run_op("max", 1, 9'h1FF);
    set_lane(1, 8'h00, 8'h00, 1'b0);
    run_op("zero", 1, 9'h000);
    req_valid = '0;

    // 5. Backpressure: pointer is 2, lanes 0 and 3 valid, so lane 3 wins.
    set_lane(0, 8'h01, 8'h01, 1'b0);
    set_lane(3, 8'h12, 8'h34, 1'b0);   // 0x046
    req_valid = 4'b1001;
    rsp_ready = 1'b0;
    #1;
    check("bp_ready", 32'(req_ready), 32'h8);
    tick();
    tick();
    for (int c = 0; c < 5; c++) begin
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_sum",   32'(rsp_sum),   32'h046);
      check("bp_id",    32'(rsp_id),    32'd3);
      check("bp_noready", 32'(req_ready), 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_hs_ready", 32'(req_ready), 32'd0);
    tick();
    check("bp_after_valid", 32'(rsp_valid), 32'd0);
    check("bp_next_gnt",    32'(req_ready), 32'h1);
    req_valid = '0;

    // 6. Reset while in CALC: no response, pointer back to 0.
    tick();
    set_lane(1, 8'h05, 8'h06, 1'b0);
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_valid", 32'(rsp_valid), 32'd0);
    check("midrst_sum",   32'(rsp_sum),   32'd0);
    tick();
    check("midrst_no_rsp", 32'(rsp_valid), 32'd0);
    req_valid = 4'b1111;
    #1;
    check("midrst_ptr", 32'(req_ready), 32'h1);
    req_valid = '0;

`ifdef ADDER_ARBITER_STATS_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("cnt_rst", 32'(op_cnt), 32'd0);
    set_lane(0, 8'h01, 8'h02, 1'b0);
    req_valid = 4'b0001;
    run_op("cnt_a", 0, 9'h003);
    run_op("cnt_b", 0, 9'h003);
    run_op("cnt_c", 0, 9'h003);
    req_valid = '0;
    check("cnt_three", 32'(op_cnt), 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("cnt_clear", 32'(op_cnt), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
